// File: rtl/apb_alu_pkg.sv
// Shared definitions for the APB ALU slave: opcodes, register offsets,
// STATUS bit positions, FSM state encoding and the debug view.
package apb_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SHL = 4'd5,
    OP_SHR = 4'd6,
    OP_MUL = 4'd7
  } opcode_e;

  // Register index is the word offset, i.e. PADDR[4:2].
  localparam logic [2:0] REG_OPA       = 3'd0;
  localparam logic [2:0] REG_OPB       = 3'd1;
  localparam logic [2:0] REG_CTRL      = 3'd2;
  localparam logic [2:0] REG_RESULT    = 3'd3;
  localparam logic [2:0] REG_RESULT_HI = 3'd4;
  localparam logic [2:0] REG_STATUS    = 3'd5;

  localparam int ST_BUSY  = 0;
  localparam int ST_DONE  = 1;
  localparam int ST_CARRY = 2;
  localparam int ST_ZERO  = 3;
  localparam int ST_OVF   = 4;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_EXEC = 2'd1;
  localparam state_t S_MUL  = 2'd2;

  typedef struct packed {
    state_t state;
    logic   mul_busy;
  } dbg_t;

  // Opcodes 8..15 are reserved; only the top bit needs looking at.
  function automatic logic opcode_valid(input logic [3:0] op);
    return ~op[3];
  endfunction

endpackage

// File: rtl/apb_alu_slave_if.sv
// APB bus bundle between the master and the ALU slave.
// Handshake: a transfer is in its access phase while PSEL&PENABLE; it
// completes (and has its effect) on the clock edge where PREADY is also 1.
// PRDATA and PSLVERR are only meaningful in that completing cycle.
interface apb_alu_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  i_PSEL;
  logic                  i_PENABLE;
  logic                  i_PWRITE;
  logic [ADDR_WIDTH-1:0] i_PADDR;
  logic [DATA_WIDTH-1:0] i_PWDATA;
  logic                  o_PREADY;
  logic [DATA_WIDTH-1:0] o_PRDATA;
  logic                  o_PSLVERR;

  modport master (
    output i_PSEL, i_PENABLE, i_PWRITE, i_PADDR, i_PWDATA,
    input  o_PREADY, o_PRDATA, o_PSLVERR
  );

  modport slave (
    input  i_PSEL, i_PENABLE, i_PWRITE, i_PADDR, i_PWDATA,
    output o_PREADY, o_PRDATA, o_PSLVERR
  );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier producing a 2*WIDTH product.
// The first partial product is folded into the load cycle, so o_done
// pulses WIDTH-1 cycles after i_start and the product is final with it.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);
  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // One shift-add step: upper half accumulates the multiplicand when the
  // current multiplier bit (LSB) is set, then the whole register shifts right.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] p,
                                                  input logic [WIDTH-1:0]   a);
    logic [WIDTH:0] s;
    s = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, a} : {(WIDTH+1){1'b0}});
    return {s, p[WIDTH-1:1]};
  endfunction

  // Next-state: load with first step, then WIDTH-1 further steps.
  always_comb begin
    prod_d = prod_q;
    a_d    = a_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (i_start) begin
      a_d    = i_a;
      prod_d = mul_step({{WIDTH{1'b0}}, i_b}, i_a);
      cnt_d  = CW'(WIDTH - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      prod_d = mul_step(prod_q, a_q);
      cnt_d  = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      a_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      prod_q <= prod_d;
      a_q    <= a_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_product = prod_q;

endmodule

// File: rtl/apb_alu_slave.sv
// APB slave fronting a register-mapped ALU: bus decode, operand/opcode
// registers, single-cycle datapath, result/flag registers and the
// IDLE/EXEC/MUL sequencer. Result reads stall with PREADY=0 while busy.
module apb_alu_slave
  import apb_alu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic           i_PCLK,
  input  logic           i_PRESETn,
  apb_alu_slave_if.slave apb,
  output logic           o_irq,
  output dbg_t           o_dbg
);
  localparam int SHW       = $clog2(DATA_WIDTH);
  localparam int MSB       = DATA_WIDTH - 1;
  localparam int START_BIT = DATA_WIDTH - 1;  // CTRL start is the word MSB

  logic [DATA_WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [DATA_WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d;
  logic [3:0]            opcode_q, opcode_d;
  logic                  done_q, done_d, carry_q, carry_d;
  logic                  zero_q, zero_d, ovf_q, ovf_d;
  state_t                state_q, state_d;

  logic [2:0]              idx;
  logic                    busy, access, rd_access, pready, commit;
  logic                    err, is_start, wr_ok, rd_commit, mul_start;
  logic                    mul_busy, mul_done;
  logic [2*DATA_WIDTH-1:0] mul_prod;
  logic [DATA_WIDTH-1:0]   rdata, status;
  logic [DATA_WIDTH-1:0]   alu_res;
  logic                    alu_c, alu_v;
  logic [DATA_WIDTH:0]     sum_ext;
  logic                    unused_addr;

  assign idx         = apb.i_PADDR[4:2];
  assign unused_addr = ^{apb.i_PADDR[ADDR_WIDTH-1:5], apb.i_PADDR[1:0]};
  assign busy        = (state_q != S_IDLE);
  assign access      = apb.i_PSEL & apb.i_PENABLE;
  assign rd_access   = access & ~apb.i_PWRITE;
  assign pready      = ~(rd_access & busy &
                         ((idx == REG_RESULT) || (idx == REG_RESULT_HI)));
  assign commit      = access & pready;
  assign is_start    = (idx == REG_CTRL) & apb.i_PWDATA[START_BIT];
  assign wr_ok       = commit & apb.i_PWRITE & ~err;
  assign rd_commit   = commit & ~apb.i_PWRITE;

  // Error decode: unmapped, RO write, invalid start opcode, write while busy.
  always_comb begin
    err = 1'b0;
    if (idx > REG_STATUS) begin
      err = 1'b1;
    end else if (apb.i_PWRITE) begin
      err = (idx >= REG_RESULT) | busy |
            (is_start & ~opcode_valid(apb.i_PWDATA[3:0]));
    end
  end

  // STATUS word assembly.
  always_comb begin
    status           = '0;
    status[ST_BUSY]  = busy;
    status[ST_DONE]  = done_q;
    status[ST_CARRY] = carry_q;
    status[ST_ZERO]  = zero_q;
    status[ST_OVF]   = ovf_q;
  end

  // Read mux; zero outside read accesses and for unmapped offsets.
  always_comb begin
    rdata = '0;
    if (rd_access) begin
      case (idx)
        REG_OPA:       rdata = opa_q;
        REG_OPB:       rdata = opb_q;
        REG_CTRL:      rdata = {{(DATA_WIDTH-4){1'b0}}, opcode_q};
        REG_RESULT:    rdata = result_q;
        REG_RESULT_HI: rdata = result_hi_q;
        REG_STATUS:    rdata = status;
        default:       rdata = '0;
      endcase
    end
  end

  // Single-cycle datapath for opcodes 0..6, driven from the held registers.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    sum_ext = '0;
    case (opcode_q)
      OP_ADD: begin
        sum_ext = {1'b0, opa_q} + {1'b0, opb_q};
        alu_res = sum_ext[DATA_WIDTH-1:0];
        alu_c   = sum_ext[DATA_WIDTH];
        alu_v   = (opa_q[MSB] == opb_q[MSB]) && (alu_res[MSB] != opa_q[MSB]);
      end
      OP_SUB: begin
        sum_ext = {1'b0, opa_q} - {1'b0, opb_q};
        alu_res = sum_ext[DATA_WIDTH-1:0];
        alu_c   = sum_ext[DATA_WIDTH];  // borrow
        alu_v   = (opa_q[MSB] != opb_q[MSB]) && (alu_res[MSB] != opa_q[MSB]);
      end
      OP_AND:  alu_res = opa_q & opb_q;
      OP_OR:   alu_res = opa_q | opb_q;
      OP_XOR:  alu_res = opa_q ^ opb_q;
      OP_SHL:  alu_res = opa_q << opb_q[SHW-1:0];
      OP_SHR:  alu_res = opa_q >> opb_q[SHW-1:0];
      default: alu_res = '0;
    endcase
  end

  // Register writes, start/launch, result capture and sequencer.
  always_comb begin
    opa_d       = opa_q;
    opb_d       = opb_q;
    opcode_d    = opcode_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    done_d      = done_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    state_d     = state_q;
    mul_start   = 1'b0;

    if (wr_ok) begin
      case (idx)
        REG_OPA: opa_d = apb.i_PWDATA;
        REG_OPB: opb_d = apb.i_PWDATA;
        REG_CTRL: begin
          opcode_d = apb.i_PWDATA[3:0];
          if (apb.i_PWDATA[START_BIT]) begin
            done_d = 1'b0;
            if (apb.i_PWDATA[3:0] == OP_MUL) begin
              mul_start = 1'b1;
              state_d   = S_MUL;
            end else begin
              state_d = S_EXEC;
            end
          end
        end
        default: ;
      endcase
    end

    // Result reads only commit when idle, so this never races a capture.
    if (rd_commit && (idx == REG_RESULT)) done_d = 1'b0;

    case (state_q)
      S_IDLE: ;
      S_EXEC: begin
        result_d    = alu_res;
        result_hi_d = '0;
        carry_d     = alu_c;
        ovf_d       = alu_v;
        zero_d      = (alu_res == '0);
        done_d      = 1'b1;
        state_d     = S_IDLE;
      end
      S_MUL: begin
        if (mul_done) begin
          result_d    = mul_prod[DATA_WIDTH-1:0];
          result_hi_d = mul_prod[2*DATA_WIDTH-1:DATA_WIDTH];
          carry_d     = 1'b0;
          ovf_d       = 1'b0;
          zero_d      = (mul_prod == '0);
          done_d      = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
    if (!i_PRESETn) begin
      opa_q       <= '0;
      opb_q       <= '0;
      opcode_q    <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      done_q      <= 1'b0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      state_q     <= S_IDLE;
    end else begin
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      opcode_q    <= opcode_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      done_q      <= done_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      state_q     <= state_d;
    end
  end

  alu_mul_iter #(.WIDTH(DATA_WIDTH)) u_mul (
    .clk       (i_PCLK),
    .rst_n     (i_PRESETn),
    .i_start   (mul_start),
    .i_a       (opa_q),
    .i_b       (opb_q),
    .o_busy    (mul_busy),
    .o_done    (mul_done),
    .o_product (mul_prod)
  );

  assign apb.o_PREADY  = pready;
  assign apb.o_PRDATA  = rdata;
  assign apb.o_PSLVERR = commit & err;
  assign o_irq         = done_q;
  assign o_dbg         = '{state: state_q, mul_busy: mul_busy};

endmodule

// File: tb/tb_apb_alu_slave.sv
// Directed plus randomized bench for apb_alu_slave with an arithmetic
// reference model and an expected-value queue.
module tb_apb_alu_slave;
  import apb_alu_pkg::*;

  localparam int WAIT_BUDGET = 64;
  localparam logic [31:0] A_OPA = 32'h00, A_OPB = 32'h04, A_CTRL = 32'h08;
  localparam logic [31:0] A_RES = 32'h0C, A_HI = 32'h10, A_STAT = 32'h14;
  localparam logic [31:0] A_BAD = 32'h18;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  apb_alu_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  logic irq;
  dbg_t dbg;

  apb_alu_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .i_PCLK    (clk),
    .i_PRESETn (rst_n),
    .apb       (bus),
    .o_irq     (irq),
    .o_dbg     (dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_exp(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    e = exp_q.pop_front();
    check(tag, obs, e);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_opa, m_opb, m_res, m_hi;
  logic [3:0]  m_op;
  logic        m_done, m_carry, m_zero, m_ovf;

  function automatic void model_reset();
    m_opa = 0; m_opb = 0; m_res = 0; m_hi = 0; m_op = 0;
    m_done = 0; m_carry = 0; m_zero = 0; m_ovf = 0;
  endfunction

  function automatic logic [31:0] exp_status(input logic busy_bit);
    return {27'b0, m_ovf, m_zero, m_carry, m_done, busy_bit};
  endfunction

  // Result of an operation computed with plain wide arithmetic.
  function automatic void model_finish(input logic [3:0] op);
    longint unsigned ua, ub, full;
    longint sa, sb, ss;
    ua = {32'b0, m_opa};
    ub = {32'b0, m_opb};
    sa = longint'($signed(m_opa));
    sb = longint'($signed(m_opb));
    m_hi = 0; m_carry = 0; m_ovf = 0; full = 0; ss = 0;
    case (op)
      4'd0: begin
        full = ua + ub; m_res = full[31:0]; m_carry = full[32];
        ss = sa + sb; m_ovf = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      4'd1: begin
        m_res = m_opa - m_opb; m_carry = (ua < ub);
        ss = sa - sb; m_ovf = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      4'd2: m_res = m_opa & m_opb;
      4'd3: m_res = m_opa | m_opb;
      4'd4: m_res = m_opa ^ m_opb;
      4'd5: m_res = m_opa << (m_opb % 32);
      4'd6: m_res = m_opa >> (m_opb % 32);
      default: begin
        full = ua * ub; m_res = full[31:0]; m_hi = full[63:32];
      end
    endcase
    m_zero = (m_res == 0) && (m_hi == 0);
    m_done = 1;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      default: return $urandom();
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int waits);
    @(negedge clk);
    bus.i_PSEL = 1'b1; bus.i_PENABLE = 1'b0; bus.i_PWRITE = wr;
    bus.i_PADDR = addr; bus.i_PWDATA = wdata;
    @(negedge clk);
    bus.i_PENABLE = 1'b1;
    waits = 0;
    #1;
    while (!bus.o_PREADY && waits < WAIT_BUDGET) begin
      @(negedge clk); #1;
      waits++;
    end
    if (!bus.o_PREADY) check("pready_timeout", {31'b0, bus.o_PREADY}, 32'd1);
    rdata = bus.o_PRDATA;
    err   = bus.o_PSLVERR;
    @(posedge clk); #1;
    bus.i_PSEL = 1'b0; bus.i_PENABLE = 1'b0; bus.i_PWRITE = 1'b0;
  endtask

  task automatic apb_wr(input logic [31:0] addr, input logic [31:0] data, output logic err);
    logic [31:0] d;
    int w;
    apb_xfer(1'b1, addr, data, d, err, w);
  endtask

  task automatic apb_rd(input logic [31:0] addr, output logic [31:0] data,
                        output logic err, output int waits);
    apb_xfer(1'b0, addr, 32'h0, data, err, waits);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] rd_data;
  logic        err;
  int          waits;
  logic [3:0]  op;
  logic [31:0] addrs[6];

  initial begin
    bus.i_PSEL = 0; bus.i_PENABLE = 0; bus.i_PWRITE = 0;
    bus.i_PADDR = 0; bus.i_PWDATA = 0;
    model_reset();
    addrs = '{A_OPA, A_OPB, A_CTRL, A_RES, A_HI, A_STAT};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_pready", {31'b0, bus.o_PREADY}, 32'd1);
    check("rst_prdata", bus.o_PRDATA, 32'd0);
    check("rst_pslverr", {31'b0, bus.o_PSLVERR}, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      apb_rd(addrs[i], rd_data, err, waits);
      check("rst_reg_val", rd_data, 32'd0);
      check("rst_reg_err", {31'b0, err}, 32'd0);
      check("rst_reg_waits", waits, 32'd0);
    end

    // ADD with carry-out to zero, then done cleared by RESULT read
    apb_wr(A_OPA, 32'hFFFF_FFFF, err); m_opa = 32'hFFFF_FFFF;
    apb_wr(A_OPB, 32'h1, err);         m_opb = 32'h1;
    apb_wr(A_CTRL, 32'h8000_0000, err); m_op = 4'd0; m_done = 0;
    check("add_start_err", {31'b0, err}, 32'd0);
    check("add_busy_now", {30'b0, dbg.state}, 32'(S_EXEC));
    check("add_irq_now", {31'b0, irq}, 32'd0);
    @(posedge clk); #1;
    model_finish(4'd0);
    check("add_irq_next", {31'b0, irq}, 32'd1);
    apb_rd(A_STAT, rd_data, err, waits);
    check("add_status", rd_data, 32'h0E);
    apb_rd(A_RES, rd_data, err, waits);
    check("add_result", rd_data, m_res);
    m_done = 0;
    apb_rd(A_STAT, rd_data, err, waits);
    check("add_status_clr", rd_data, exp_status(1'b0));
    apb_rd(A_CTRL, rd_data, err, waits);
    check("ctrl_readback", rd_data, 32'h0);

    // SUB then ADD around the signed boundary
    apb_wr(A_OPA, 32'h7FFF_FFFF, err); m_opa = 32'h7FFF_FFFF;
    apb_wr(A_OPB, 32'h1, err);
    apb_wr(A_CTRL, 32'h8000_0001, err); m_op = 4'd1; model_finish(4'd1);
    apb_rd(A_RES, rd_data, err, waits);
    check("sub_result", rd_data, 32'h7FFF_FFFE);
    check("sub_res_model", rd_data, m_res);
    m_done = 0;
    apb_rd(A_STAT, rd_data, err, waits);
    check("sub_status", rd_data, exp_status(1'b0));
    apb_wr(A_CTRL, 32'h8000_0000, err); m_op = 4'd0; model_finish(4'd0);
    apb_rd(A_STAT, rd_data, err, waits);
    check("addv_status", rd_data, 32'h12);
    apb_rd(A_RES, rd_data, err, waits);
    check("addv_result", rd_data, 32'h8000_0000);
    m_done = 0;

    // MUL with immediate RESULT read: wait states until busy falls
    apb_wr(A_OPA, 32'hFFFF_FFFF, err); m_opa = 32'hFFFF_FFFF;
    apb_wr(A_OPB, 32'hFFFF_FFFF, err); m_opb = 32'hFFFF_FFFF;
    apb_wr(A_CTRL, 32'h8000_0007, err); m_op = 4'd7; model_finish(4'd7);
    apb_rd(A_RES, rd_data, err, waits);
    check("mul_result", rd_data, 32'h0000_0001);
    check("mul_waits", waits, 32'd31);
    apb_rd(A_HI, rd_data, err, waits);
    check("mul_result_hi", rd_data, 32'hFFFF_FFFE);
    check("mul_hi_model", rd_data, m_hi);
    m_done = 0;
    apb_rd(A_STAT, rd_data, err, waits);
    check("mul_status", rd_data, exp_status(1'b0));

    // Randomized operations against the model
    for (int i = 0; i < 24; i++) begin
      op    = 4'($urandom_range(0, 7));
      m_opa = pick();
      m_opb = pick();
      apb_wr(A_OPA, m_opa, err);
      apb_wr(A_OPB, m_opb, err);
      apb_wr(A_CTRL, 32'h8000_0000 | {28'b0, op}, err);
      check("rand_start_err", {31'b0, err}, 32'd0);
      m_op = op;
      model_finish(op);
      exp_q.push_back(m_hi);
      exp_q.push_back(exp_status(1'b0));
      exp_q.push_back(m_res);
      apb_rd(A_HI, rd_data, err, waits);
      check_exp("rand_result_hi", rd_data);
      apb_rd(A_STAT, rd_data, err, waits);
      check_exp("rand_status", rd_data);
      apb_rd(A_RES, rd_data, err, waits);
      check_exp("rand_result", rd_data);
      m_done = 0;
    end

    // Error responses
    apb_wr(A_OPA, 32'd5, err); m_opa = 32'd5;
    apb_wr(A_OPB, 32'd7, err); m_opb = 32'd7;
    apb_wr(A_CTRL, 32'h8000_0007, err); m_op = 4'd7; m_done = 0;
    apb_wr(A_OPA, 32'h1234, err);
    check("busy_wr_opa_err", {31'b0, err}, 32'd1);
    apb_wr(A_CTRL, 32'h8000_0000, err);
    check("busy_start_err", {31'b0, err}, 32'd1);
    apb_rd(A_STAT, rd_data, err, waits);
    check("busy_status", rd_data, exp_status(1'b1));
    check("busy_status_waits", waits, 32'd0);
    apb_wr(A_BAD, 32'hDEAD_BEEF, err);
    check("unmapped_wr_err", {31'b0, err}, 32'd1);
    apb_rd(A_BAD, rd_data, err, waits);
    check("unmapped_rd_err", {31'b0, err}, 32'd1);
    check("unmapped_rd_data", rd_data, 32'd0);
    model_finish(4'd7);
    apb_rd(A_RES, rd_data, err, waits);
    check("err_mul_result", rd_data, m_res);
    m_done = 0;
    apb_rd(A_OPA, rd_data, err, waits);
    check("opa_unchanged", rd_data, m_opa);
    apb_wr(A_RES, 32'h55, err);
    check("ro_wr_err", {31'b0, err}, 32'd1);
    apb_wr(A_STAT, 32'h55, err);
    check("ro_stat_err", {31'b0, err}, 32'd1);
    apb_wr(A_CTRL, 32'h8000_0009, err);
    check("badop_err", {31'b0, err}, 32'd1);
    check("badop_idle", {30'b0, dbg.state}, 32'(S_IDLE));
    apb_rd(A_CTRL, rd_data, err, waits);
    check("badop_ctrl", rd_data, {28'b0, m_op});
    apb_wr(A_CTRL, 32'h0000_0003, err); m_op = 4'd3;
    check("opcode_only_err", {31'b0, err}, 32'd0);
    check("opcode_only_idle", {30'b0, dbg.state}, 32'(S_IDLE));
    apb_rd(A_CTRL, rd_data, err, waits);
    check("opcode_only_ctrl", rd_data, 32'd3);
    apb_rd(A_STAT, rd_data, err, waits);
    check("opcode_only_status", rd_data, exp_status(1'b0));

    // Reset in the middle of a multiply
    apb_wr(A_OPA, 32'h0001_FFFF, err);
    apb_wr(A_OPB, 32'h0003_0001, err);
    apb_wr(A_CTRL, 32'h8000_0007, err);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_idle", {30'b0, dbg.state}, 32'(S_IDLE));
    check("midrst_irq", {31'b0, irq}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    apb_rd(A_STAT, rd_data, err, waits);
    check("midrst_status", rd_data, 32'd0);
    apb_rd(A_RES, rd_data, err, waits);
    check("midrst_result", rd_data, 32'd0);
    apb_rd(A_OPA, rd_data, err, waits);
    check("midrst_opa", rd_data, 32'd0);
    apb_wr(A_OPA, 32'd3, err); m_opa = 32'd3;
    apb_wr(A_OPB, 32'd4, err); m_opb = 32'd4;
    apb_wr(A_CTRL, 32'h8000_0007, err); m_op = 4'd7; model_finish(4'd7);
    apb_rd(A_RES, rd_data, err, waits);
    check("post_rst_mul", rd_data, 32'd12);
    check("post_rst_waits", waits, 32'd31);
    m_done = 0;
    apb_rd(A_STAT, rd_data, err, waits);
    check("post_rst_status", rd_data, exp_status(1'b0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
